// File: rtl/comm_frame_store.sv
// comm_frame_store
//   Double-buffered 1024x12 frame store. The shared common port writes and
//   reads the fill bank; a small drain FSM streams the other bank out over a
//   valid/ready handshake after each frameDone, swapping the banks.
//
// Build option:
//   FS_CLEAR_ON_READ_EN  defined  : each accepted drain word is zeroed in the
//                                   drain bank on its handshake cycle.
//                        undefined: the drain bank is read-only.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   commWrdOut/Addr   common-port write data/address, commWren write strobe
//   commOldWrdAddr    common-port read address, commOldRdEn read strobe
//   commOldWrd        fill-bank read data, one cycle after commOldRdEn
//   frameDone         pulse: fill bank complete, swap and start draining
//   outWrd/outAddr    streamed word and its index, qualified by outValid
//   outReady          downstream accept
//   bankSel           current fill bank (drain bank is ~bankSel)
//   overrun           sticky: a frameDone arrived while a frame was draining
//
// Drain FSM states:
//   state | meaning
//   IDLE  | no frame pending, waiting for frameDone
//   FETCH | reading drain[drainAddr] into outWrd
//   SEND  | outWrd/outAddr presented, waiting for outReady
module comm_frame_store #(
    parameter int FRAME_LEN = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] commWrdOut,
    input  logic [9:0]  commWrdAddr,
    input  logic        commWren,
    input  logic [9:0]  commOldWrdAddr,
    input  logic        commOldRdEn,
    output logic [11:0] commOldWrd,
    input  logic        frameDone,
    output logic [11:0] outWrd,
    output logic [9:0]  outAddr,
    output logic        outValid,
    input  logic        outReady,
    output logic        bankSel,
    output logic        overrun
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND
    } stateT;

    localparam logic [9:0] LAST_ADDR = 10'(FRAME_LEN - 1);

    // Both banks live in one array; the bank number is the top address bit.
    logic [11:0] mem [0:2047];

    stateT       state;
    stateT       stateNext;
    logic [9:0]  drainAddr;
    logic        handshake;
    logic        swapBanks;
    logic        addrInc;
    logic        dropFrame;

    assign handshake = (state == SEND) && outReady;
    assign outValid  = (state == SEND);
    assign outAddr   = drainAddr;

    always_comb begin
        stateNext = state;
        swapBanks = 1'b0;
        addrInc   = 1'b0;
        case (state)
            IDLE: begin
                if (frameDone) begin
                    swapBanks = 1'b1;
                    stateNext = FETCH;
                end
            end
            FETCH: begin
                stateNext = SEND;
            end
            SEND: begin
                if (outReady) begin
                    if (drainAddr == LAST_ADDR) begin
                        // A frameDone landing on the last handshake is not
                        // an overrun: the drain bank is free from this edge.
                        if (frameDone) begin
                            swapBanks = 1'b1;
                            stateNext = FETCH;
                        end else begin
                            stateNext = IDLE;
                        end
                    end else begin
                        addrInc   = 1'b1;
                        stateNext = FETCH;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        dropFrame = frameDone && !swapBanks;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bankSel    <= 1'b0;
            drainAddr  <= '0;
            outWrd     <= '0;
            commOldWrd <= '0;
            overrun    <= 1'b0;
        end else begin
            state <= stateNext;
            if (swapBanks) begin
                bankSel   <= ~bankSel;
                drainAddr <= '0;
            end else if (addrInc) begin
                drainAddr <= drainAddr + 10'd1;
            end
            if (state == FETCH) begin
                outWrd <= mem[{~bankSel, drainAddr}];
            end
            // Non-blocking read of the array gives pre-write data on a
            // same-address read/write collision.
            if (commOldRdEn) begin
                commOldWrd <= mem[{bankSel, commOldWrdAddr}];
            end
            if (dropFrame) begin
                overrun <= 1'b1;
            end
        end
    end

    // Storage is never reset. The common port and the clear-on-read port
    // always address opposite banks, so they never collide.
    always_ff @(posedge clk) begin
        if (commWren && !reset) begin
            mem[{bankSel, commWrdAddr}] <= commWrdOut;
        end
`ifdef FS_CLEAR_ON_READ_EN
        if (handshake && !reset) begin
            mem[{~bankSel, drainAddr}] <= '0;
        end
`endif
    end

endmodule

// File: tb/tb_comm_frame_store.sv
module tb_comm_frame_store;

    localparam int FRAME_LEN = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] commWrdOut;
    logic [9:0]  commWrdAddr;
    logic        commWren;
    logic [9:0]  commOldWrdAddr;
    logic        commOldRdEn;
    logic [11:0] commOldWrd;
    logic        frameDone;
    logic [11:0] outWrd;
    logic [9:0]  outAddr;
    logic        outValid;
    logic        outReady;
    logic        bankSel;
    logic        overrun;

    always #5 clk = ~clk;

    comm_frame_store #(.FRAME_LEN(FRAME_LEN)) dut (
        .clk            (clk),
        .reset          (reset),
        .commWrdOut     (commWrdOut),
        .commWrdAddr    (commWrdAddr),
        .commWren       (commWren),
        .commOldWrdAddr (commOldWrdAddr),
        .commOldRdEn    (commOldRdEn),
        .commOldWrd     (commOldWrd),
        .frameDone      (frameDone),
        .outWrd         (outWrd),
        .outAddr        (outAddr),
        .outValid       (outValid),
        .outReady       (outReady),
        .bankSel        (bankSel),
        .overrun        (overrun)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: two banks as plain arrays, a known-bit per word since
    // the RAM is never initialised, and a queue holding the frame that the
    // drain side still owes us.
    typedef struct {
        logic [9:0]  addr;
        logic [11:0] word;
        bit          known;
    } drainWordT;

    typedef struct {
        logic        wren;
        logic [9:0]  waddr;
        logic [11:0] wdata;
        logic        rden;
        logic [9:0]  raddr;
        logic [11:0] expOld;
    } tableVecT;

    logic [11:0] mMem [2][1024];
    bit          mKnown [2][1024];
    bit          mBank = 1'b0;
    bit          mOver = 1'b0;
    logic [11:0] mOld = '0;
    bit          mOldKnown = 1'b1;
    drainWordT   expQ [$];
    logic [11:0] rxQ [$];

    logic [11:0] wordsA [4] = '{12'd10, 12'd20, 12'd30, 12'd40};
    logic [11:0] wordsB [4] = '{12'd50, 12'd60, 12'd70, 12'd80};
    logic [11:0] wordsD [4] = '{12'd100, 12'd200, 12'd300, 12'd400};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: update the model with the inputs present for this edge,
    // let the edge happen, then compare.
    task automatic step();
        bit          hs;
        bit          holdPrev;
        bit          wasReset;
        bit          drainBank;
        logic [11:0] prevWrd;
        logic [9:0]  prevAddr;
        drainWordT   w;
        wasReset = reset;
        hs       = outValid && outReady && !reset;
        holdPrev = outValid && !outReady && !reset;
        prevWrd  = outWrd;
        prevAddr = outAddr;
        if (wasReset) begin
            mBank     = 1'b0;
            mOver     = 1'b0;
            mOld      = '0;
            mOldKnown = 1'b1;
            expQ.delete();
        end else begin
            if (commOldRdEn) begin
                mOld      = mMem[mBank][commOldWrdAddr];
                mOldKnown = mKnown[mBank][commOldWrdAddr];
            end
            if (commWren) begin
                mMem[mBank][commWrdAddr]   = commWrdOut;
                mKnown[mBank][commWrdAddr] = 1'b1;
            end
            if (hs) begin
                if (expQ.size() == 0) begin
                    check("spurious handshake", 32'(outValid), 32'd0);
                end else begin
                    w = expQ.pop_front();
                    rxQ.push_back(outWrd);
                    check("drain outAddr", 32'(outAddr), 32'(w.addr));
                    if (w.known) check("drain outWrd", 32'(outWrd), 32'(w.word));
`ifdef FS_CLEAR_ON_READ_EN
                    mMem[mBank ^ 1'b1][w.addr]   = '0;
                    mKnown[mBank ^ 1'b1][w.addr] = 1'b1;
`endif
                end
            end
            if (frameDone) begin
                if (expQ.size() == 0) begin
                    mBank     = ~mBank;
                    drainBank = ~mBank;
                    for (int a = 0; a < FRAME_LEN; a++) begin
                        expQ.push_back('{addr: 10'(a), word: mMem[drainBank][a],
                                         known: mKnown[drainBank][a]});
                    end
                end else begin
                    mOver = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (mOldKnown) check("commOldWrd", 32'(commOldWrd), 32'(mOld));
        check("bankSel", 32'(bankSel), 32'(mBank));
        check("overrun", 32'(overrun), 32'(mOver));
        if (expQ.size() == 0) check("outValid with no frame pending", 32'(outValid), 32'd0);
        if (holdPrev) begin
            check("SEND hold outValid", 32'(outValid), 32'd1);
            check("SEND hold outWrd", 32'(outWrd), 32'(prevWrd));
            check("SEND hold outAddr", 32'(outAddr), 32'(prevAddr));
        end
        if (wasReset) begin
            check("reset outValid", 32'(outValid), 32'd0);
            check("reset outWrd", 32'(outWrd), 32'd0);
            check("reset outAddr", 32'(outAddr), 32'd0);
        end
    endtask

    task automatic clearIn();
        reset          = 1'b0;
        commWren       = 1'b0;
        commWrdAddr    = '0;
        commWrdOut     = '0;
        commOldRdEn    = 1'b0;
        commOldWrdAddr = '0;
        frameDone      = 1'b0;
        outReady       = 1'b0;
    endtask

    task automatic writeWord(input logic [9:0] addr, input logic [11:0] data);
        commWren    = 1'b1;
        commWrdAddr = addr;
        commWrdOut  = data;
        step();
        commWren    = 1'b0;
    endtask

    task automatic pulseFrameDone();
        frameDone = 1'b1;
        step();
        frameDone = 1'b0;
    endtask

    task automatic waitValid(input int bound, input string name);
        for (int i = 0; i < bound; i++) begin
            if (outValid) break;
            step();
        end
        check(name, 32'(outValid), 32'd1);
    endtask

    task automatic drainAll(input int bound, input string name);
        outReady = 1'b1;
        for (int i = 0; i < bound && expQ.size() > 0; i++) step();
        check(name, 32'(expQ.size()), 32'd0);
    endtask

    function automatic logic [9:0] pickAddr();
        if ($urandom_range(0, 1) == 1) return 10'($urandom_range(0, 15));
        return 10'($urandom);
    endfunction

    tableVecT tbl [11];
    bit       found;

    initial begin
        tbl[0]  = '{1'b1, 10'd5,    12'hABC, 1'b0, 10'd0,    12'h000};
        tbl[1]  = '{1'b0, 10'd0,    12'h000, 1'b1, 10'd5,    12'hABC};
        tbl[2]  = '{1'b0, 10'd0,    12'h000, 1'b0, 10'd0,    12'hABC};
        tbl[3]  = '{1'b1, 10'd7,    12'h222, 1'b0, 10'd0,    12'hABC};
        tbl[4]  = '{1'b1, 10'd7,    12'h111, 1'b1, 10'd7,    12'h222};
        tbl[5]  = '{1'b0, 10'd0,    12'h000, 1'b1, 10'd7,    12'h111};
        tbl[6]  = '{1'b1, 10'd1023, 12'hFFF, 1'b1, 10'd5,    12'hABC};
        tbl[7]  = '{1'b0, 10'd0,    12'h000, 1'b1, 10'd1023, 12'hFFF};
        tbl[8]  = '{1'b0, 10'd0,    12'h000, 1'b0, 10'd0,    12'hFFF};
        tbl[9]  = '{1'b1, 10'd0,    12'h5A5, 1'b1, 10'd1023, 12'hFFF};
        tbl[10] = '{1'b0, 10'd0,    12'h000, 1'b1, 10'd0,    12'h5A5};

        clearIn();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("reset commOldWrd", 32'(commOldWrd), 32'd0);

        // Common port: write/read, hold, read-before-write, address extremes.
        for (int i = 0; i < 11; i++) begin
            commWren       = tbl[i].wren;
            commWrdAddr    = tbl[i].waddr;
            commWrdOut     = tbl[i].wdata;
            commOldRdEn    = tbl[i].rden;
            commOldWrdAddr = tbl[i].raddr;
            step();
            check($sformatf("table[%0d] commOldWrd", i), 32'(commOldWrd), 32'(tbl[i].expOld));
        end
        clearIn();

        // Frame A: full-rate drain of bank 0.
        rxQ.delete();
        for (int i = 0; i < 4; i++) writeWord(10'(i), wordsA[i]);
        outReady = 1'b1;
        pulseFrameDone();
        for (int i = 0; i < 8; i++) step();
        check("frame A word count after 8 cycles", 32'(rxQ.size()), 32'd4);
        for (int i = 0; i < 4 && i < rxQ.size(); i++)
            check($sformatf("frame A word %0d", i), 32'(rxQ[i]), 32'(wordsA[i]));
        check("frame A bankSel", 32'(bankSel), 32'd1);
        check("frame A idle outValid", 32'(outValid), 32'd0);

        // Frame B: stalled SEND with a dropped frameDone.
        rxQ.delete();
        outReady = 1'b0;
        for (int i = 0; i < 4; i++) writeWord(10'(i), wordsB[i]);
        pulseFrameDone();
        waitValid(6, "frame B first outValid");
        for (int i = 0; i < 5; i++) begin
            frameDone = (i == 2);
            step();
        end
        frameDone = 1'b0;
        check("stall outAddr", 32'(outAddr), 32'd0);
        check("stall outWrd", 32'(outWrd), 32'(wordsB[0]));
        check("dropped frameDone overrun", 32'(overrun), 32'd1);
        check("dropped frameDone bankSel", 32'(bankSel), 32'd0);
        drainAll(20, "frame B drained");
        for (int i = 0; i < 4 && i < rxQ.size(); i++)
            check($sformatf("frame B word %0d", i), 32'(rxQ[i]), 32'(wordsB[i]));

        // Frame C: re-drain bank 0 without rewriting it.
        rxQ.delete();
        outReady = 1'b1;
        pulseFrameDone();
        drainAll(20, "frame C drained");
        for (int i = 0; i < 4 && i < rxQ.size(); i++) begin
`ifdef FS_CLEAR_ON_READ_EN
            check($sformatf("frame C word %0d", i), 32'(rxQ[i]), 32'd0);
`else
            check($sformatf("frame C word %0d", i), 32'(rxQ[i]), 32'(wordsA[i]));
`endif
        end
        check("frame C word count", 32'(rxQ.size()), 32'd4);

        // Reset while in SEND, with coincident strobes that must be ignored.
        rxQ.delete();
        outReady = 1'b0;
        pulseFrameDone();
        waitValid(6, "pre-reset outValid");
        reset          = 1'b1;
        commWren       = 1'b1;
        commWrdAddr    = 10'd2;
        commWrdOut     = 12'hDEA;
        frameDone      = 1'b1;
        commOldRdEn    = 1'b1;
        commOldWrdAddr = 10'd0;
        step();
        clearIn();
        check("reset-in-SEND outValid", 32'(outValid), 32'd0);
        check("reset-in-SEND bankSel", 32'(bankSel), 32'd0);
        check("reset-in-SEND overrun", 32'(overrun), 32'd0);
        check("reset-in-SEND commOldWrd", 32'(commOldWrd), 32'd0);
        outReady = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("words after reset", 32'(rxQ.size()), 32'd0);
        commOldRdEn    = 1'b1;
        commOldWrdAddr = 10'd2;
        step();
        commOldRdEn    = 1'b0;
`ifdef FS_CLEAR_ON_READ_EN
        check("write during reset ignored", 32'(commOldWrd), 32'd0);
`else
        check("write during reset ignored", 32'(commOldWrd), 32'(wordsA[2]));
`endif

        // frameDone on the final handshake starts the next frame at once.
        rxQ.delete();
        for (int i = 0; i < 4; i++) writeWord(10'(i), wordsD[i]);
        outReady = 1'b1;
        pulseFrameDone();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (outValid && outAddr == 10'(FRAME_LEN - 1)) begin
                found     = 1'b1;
                frameDone = 1'b1;
                step();
                frameDone = 1'b0;
                break;
            end
            step();
        end
        check("final handshake reached", 32'(found), 32'd1);
        check("back-to-back bankSel", 32'(bankSel), 32'd0);
        check("back-to-back overrun", 32'(overrun), 32'd0);
        drainAll(20, "back-to-back drained");
        check("back-to-back word count", 32'(rxQ.size()), 32'd8);
        for (int i = 0; i < 8 && i < rxQ.size(); i++) begin
`ifdef FS_CLEAR_ON_READ_EN
            check($sformatf("back-to-back word %0d", i), 32'(rxQ[i]),
                  (i < 4) ? 32'(wordsD[i]) : 32'd0);
`else
            check($sformatf("back-to-back word %0d", i), 32'(rxQ[i]),
                  (i < 4) ? 32'(wordsD[i]) : 32'(wordsB[i - 4]));
`endif
        end

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 599) == 0);
            commWren       = ($urandom_range(0, 1) == 1);
            commWrdAddr    = pickAddr();
            commWrdOut     = 12'($urandom);
            commOldRdEn    = ($urandom_range(0, 1) == 1);
            commOldWrdAddr = pickAddr();
            frameDone      = ($urandom_range(0, 29) == 0);
            outReady       = ($urandom_range(0, 3) != 0);
            step();
        end
        clearIn();
        drainAll(4 * FRAME_LEN + 8, "random phase final drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
